// File: rtl/mc_ctrl_if.sv
// Control bus between the multi-cycle sequencer (master) and the MIPS datapath (slave).
interface mc_ctrl_if;
    logic [31:0] instr;
    logic        mem_ready;
    logic [2:0]  state;
    logic        ir_wr;
    logic        pc_wr;
    logic        branch;
    logic        jr_sel;
    logic        jal_sel;
    logic        reg_wr;
    logic [1:0]  reg_dst;
    logic [1:0]  mem_to_reg;
    logic        alu_src;
    logic        ext_op;
    logic [1:0]  alu_op;
    logic        mem_wr;
    logic        mem_rd;
    logic [31:0] retired;
    logic [31:0] cycles;

    modport master (
        input  instr, mem_ready,
        output state, ir_wr, pc_wr, branch, jr_sel, jal_sel, reg_wr, reg_dst,
               mem_to_reg, alu_src, ext_op, alu_op, mem_wr, mem_rd, retired, cycles
    );

    modport slave (
        output instr, mem_ready,
        input  state, ir_wr, pc_wr, branch, jr_sel, jal_sel, reg_wr, reg_dst,
               mem_to_reg, alu_src, ext_op, alu_op, mem_wr, mem_rd, retired, cycles
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS-subset CPU.
// Optional perf counters (retired/cycles) are enabled by defining MC_CTRL_PERF_EN.
module mc_ctrl (
    input  logic       clk,
    input  logic       reset,
    mc_ctrl_if.master  bus
);
    localparam int unsigned OP_W = 6;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        C_NOP, C_R, C_JR, C_I, C_LW, C_SW, C_BEQ, C_JAL
    } cls_e;

    state_e          state_q, state_d;
    logic [OP_W-1:0] op_q, funct_q;
    cls_e            cls;
    logic            unused_instr_bits;

    assign unused_instr_bits = ^bus.instr[25:6];

    // State and latched instruction fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            funct_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH) begin
                op_q    <= bus.instr[31:26];
                funct_q <= bus.instr[5:0];
            end
        end
    end

    // Instruction class from the latched fields.
    always_comb begin
        cls = C_NOP;
        case (op_q)
            6'h00: begin
                if (funct_q == 6'h21 || funct_q == 6'h23) cls = C_R;
                else if (funct_q == 6'h08)                cls = C_JR;
            end
            6'h0D, 6'h0F: cls = C_I;
            6'h23:        cls = C_LW;
            6'h2B:        cls = C_SW;
            6'h04:        cls = C_BEQ;
            6'h03:        cls = C_JAL;
            default:      cls = C_NOP;
        endcase
    end

    // Next state and control outputs; write enables are squashed while reset is high.
    always_comb begin
        state_d        = S_FETCH;
        bus.ir_wr      = 1'b0;
        bus.pc_wr      = 1'b0;
        bus.branch     = 1'b0;
        bus.jr_sel     = 1'b0;
        bus.jal_sel    = 1'b0;
        bus.reg_wr     = 1'b0;
        bus.reg_dst    = 2'd0;
        bus.mem_to_reg = 2'd0;
        bus.alu_src    = 1'b0;
        bus.ext_op     = 1'b0;
        bus.alu_op     = 2'd0;
        bus.mem_wr     = 1'b0;
        bus.mem_rd     = 1'b0;

        // Datapath selects are held from EXEC through the final state.
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            case (cls)
                C_R: begin
                    bus.alu_op  = (funct_q == 6'h23) ? 2'd1 : 2'd0;
                    bus.reg_dst = 2'd1;
                end
                C_I: begin
                    bus.alu_src = 1'b1;
                    bus.alu_op  = (op_q == 6'h0F) ? 2'd3 : 2'd2;
                end
                C_LW, C_SW: begin
                    bus.alu_src = 1'b1;
                    bus.ext_op  = 1'b1;
                end
                C_BEQ:   bus.alu_op = 2'd1;
                default: ;
            endcase
        end

        case (state_q)
            S_FETCH: begin
                bus.ir_wr = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                if (cls == C_NOP) bus.pc_wr = 1'b1;
                else              state_d   = S_EXEC;
            end
            S_EXEC: begin
                case (cls)
                    C_R, C_I:   state_d = S_WB;
                    C_LW, C_SW: state_d = S_MEM;
                    C_BEQ: begin
                        bus.pc_wr  = 1'b1;
                        bus.branch = 1'b1;
                    end
                    C_JR: begin
                        bus.pc_wr  = 1'b1;
                        bus.jr_sel = 1'b1;
                    end
                    C_JAL: begin
                        bus.pc_wr      = 1'b1;
                        bus.jal_sel    = 1'b1;
                        bus.reg_wr     = 1'b1;
                        bus.reg_dst    = 2'd2;
                        bus.mem_to_reg = 2'd2;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                if (cls == C_LW) begin
                    bus.mem_rd = 1'b1;
                    state_d    = bus.mem_ready ? S_WB : S_MEM;
                end else if (cls == C_SW) begin
                    bus.mem_wr = 1'b1;
                    bus.pc_wr  = bus.mem_ready;
                    state_d    = bus.mem_ready ? S_FETCH : S_MEM;
                end
            end
            S_WB: begin
                bus.pc_wr  = 1'b1;
                bus.reg_wr = 1'b1;
                if (cls == C_LW) bus.mem_to_reg = 2'd1;
            end
            default: state_d = S_FETCH;
        endcase

        if (reset) begin
            bus.ir_wr   = 1'b0;
            bus.pc_wr   = 1'b0;
            bus.branch  = 1'b0;
            bus.jr_sel  = 1'b0;
            bus.jal_sel = 1'b0;
            bus.reg_wr  = 1'b0;
            bus.mem_wr  = 1'b0;
            bus.mem_rd  = 1'b0;
        end
    end

    assign bus.state = state_q;

`ifdef MC_CTRL_PERF_EN
    logic [31:0] retired_q, cycles_q;

    // Free-running cycle and retired-instruction counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= '0;
            cycles_q  <= '0;
        end else begin
            cycles_q  <= cycles_q + 32'd1;
            retired_q <= retired_q + 32'(bus.pc_wr);
        end
    end

    assign bus.retired = retired_q;
    assign bus.cycles  = cycles_q;
`else
    assign bus.retired = '0;
    assign bus.cycles  = '0;
`endif
endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: driver queues per-cycle expected controls, monitor compares.
module tb_mc_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mc_ctrl_if bus ();
    mc_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [18:0] ctl;
        logic [31:0] ret;
        logic [31:0] cyc;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] m_ret  = '0;
    logic [31:0] m_cyc  = '0;

    // Field order: state, ir_wr, pc_wr, branch, jr_sel, jal_sel, reg_wr, reg_dst,
    // mem_to_reg, alu_src, ext_op, alu_op, mem_wr, mem_rd.
    function automatic logic [18:0] e(int st, int ir, int pc, int br, int jr, int jal,
                                      int rw, int rdst, int m2r, int as, int ex,
                                      int aop, int mw, int mr);
        return {3'(st), 1'(ir), 1'(pc), 1'(br), 1'(jr), 1'(jal), 1'(rw), 2'(rdst),
                2'(m2r), 1'(as), 1'(ex), 2'(aop), 1'(mw), 1'(mr)};
    endfunction

    task automatic cyc(input logic [31:0] ins, input logic rdy, input logic rst,
                       input logic [18:0] ctl, input string tag);
        exp_t x;
        bus.instr     = ins;
        bus.mem_ready = rdy;
        reset         = rst;
        x.ctl = ctl;
        x.tag = tag;
`ifdef MC_CTRL_PERF_EN
        x.ret = m_ret;
        x.cyc = m_cyc;
`else
        x.ret = '0;
        x.cyc = '0;
`endif
        sb.push_back(x);
        if (rst) begin
            m_ret = '0;
            m_cyc = '0;
        end else begin
            m_cyc = m_cyc + 32'd1;
            m_ret = m_ret + 32'(ctl[14]);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: one comparison per sampled cycle.
    always @(negedge clk) begin
        exp_t        x;
        logic [18:0] act;
        if (sb.size() > 0) begin
            x   = sb.pop_front();
            act = {bus.state, bus.ir_wr, bus.pc_wr, bus.branch, bus.jr_sel, bus.jal_sel,
                   bus.reg_wr, bus.reg_dst, bus.mem_to_reg, bus.alu_src, bus.ext_op,
                   bus.alu_op, bus.mem_wr, bus.mem_rd};
            n_cmp++;
            if ({act, bus.retired, bus.cycles} !== {x.ctl, x.ret, x.cyc}) begin
                n_fail++;
                $display("FAIL %s: got ctl=%05h retired=%0d cycles=%0d, want ctl=%05h retired=%0d cycles=%0d",
                         x.tag, act, bus.retired, bus.cycles, x.ctl, x.ret, x.cyc);
            end
        end
    end

    logic [18:0] F, D, RST0;

    initial begin
        F    = e(0,1,0,0,0,0,0,0,0,0,0,0,0,0);
        D    = e(1,0,0,0,0,0,0,0,0,0,0,0,0,0);
        RST0 = e(0,0,0,0,0,0,0,0,0,0,0,0,0,0);
        reset         = 1'b1;
        bus.instr     = '0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset held, then a nop (F-D).
        cyc(32'h0, 0, 1, RST0, "rst0");
        cyc(32'h0, 0, 1, RST0, "rst1");
        cyc(32'h0, 0, 1, RST0, "rst2");
        cyc(32'h0, 0, 0, F, "nop_f");
        cyc(32'h0, 0, 0, e(1,0,1,0,0,0,0,0,0,0,0,0,0,0), "nop_d");

        // lw with two wait cycles.
        cyc(32'h8C080004, 0, 0, F, "lw_f");
        cyc(32'h8C080004, 0, 0, D, "lw_d");
        cyc(32'h8C080004, 0, 0, e(2,0,0,0,0,0,0,0,0,1,1,0,0,0), "lw_e");
        cyc(32'h8C080004, 0, 0, e(3,0,0,0,0,0,0,0,0,1,1,0,0,1), "lw_m0");
        cyc(32'h8C080004, 0, 0, e(3,0,0,0,0,0,0,0,0,1,1,0,0,1), "lw_m1");
        cyc(32'h8C080004, 1, 0, e(3,0,0,0,0,0,0,0,0,1,1,0,0,1), "lw_m2");
        cyc(32'h8C080004, 0, 0, e(4,0,1,0,0,0,1,0,1,1,1,0,0,0), "lw_wb");

        // beq, jal, jr.
        cyc(32'h11090003, 0, 0, F, "beq_f");
        cyc(32'h11090003, 0, 0, D, "beq_d");
        cyc(32'h11090003, 0, 0, e(2,0,1,1,0,0,0,0,0,0,0,1,0,0), "beq_e");
        cyc(32'h0C000010, 0, 0, F, "jal_f");
        cyc(32'h0C000010, 0, 0, D, "jal_d");
        cyc(32'h0C000010, 0, 0, e(2,0,1,0,0,1,1,2,2,0,0,0,0,0), "jal_e");
        cyc(32'h01200008, 0, 0, F, "jr_f");
        cyc(32'h01200008, 0, 0, D, "jr_d");
        cyc(32'h01200008, 0, 0, e(2,0,1,0,1,0,0,0,0,0,0,0,0,0), "jr_e");

        // addu with mem_ready high outside MEM (ignored), then subu.
        cyc(32'h01095021, 1, 0, F, "addu_f");
        cyc(32'h01095021, 1, 0, D, "addu_d");
        cyc(32'h01095021, 1, 0, e(2,0,0,0,0,0,0,1,0,0,0,0,0,0), "addu_e");
        cyc(32'h01095021, 1, 0, e(4,0,1,0,0,0,1,1,0,0,0,0,0,0), "addu_wb");
        cyc(32'h01095023, 0, 0, F, "subu_f");
        cyc(32'h01095023, 0, 0, D, "subu_d");
        cyc(32'h01095023, 0, 0, e(2,0,0,0,0,0,0,1,0,0,0,1,0,0), "subu_e");
        cyc(32'h01095023, 0, 0, e(4,0,1,0,0,0,1,1,0,0,0,1,0,0), "subu_wb");

        // ori and lui.
        cyc(32'h3508000F, 0, 0, F, "ori_f");
        cyc(32'h3508000F, 0, 0, D, "ori_d");
        cyc(32'h3508000F, 0, 0, e(2,0,0,0,0,0,0,0,0,1,0,2,0,0), "ori_e");
        cyc(32'h3508000F, 0, 0, e(4,0,1,0,0,0,1,0,0,1,0,2,0,0), "ori_wb");
        cyc(32'h3C081234, 0, 0, F, "lui_f");
        cyc(32'h3C081234, 0, 0, D, "lui_d");
        cyc(32'h3C081234, 0, 0, e(2,0,0,0,0,0,0,0,0,1,0,3,0,0), "lui_e");
        cyc(32'h3C081234, 0, 0, e(4,0,1,0,0,0,1,0,0,1,0,3,0,0), "lui_wb");

        // sw with mem_ready already high: single MEM cycle.
        cyc(32'hAD080004, 1, 0, F, "sw_f");
        cyc(32'hAD080004, 1, 0, D, "sw_d");
        cyc(32'hAD080004, 1, 0, e(2,0,0,0,0,0,0,0,0,1,1,0,0,0), "sw_e");
        cyc(32'hAD080004, 1, 0, e(3,0,1,0,0,0,0,0,0,1,1,0,1,0), "sw_m");

        // Undefined opcode behaves as nop.
        cyc(32'hFC000000, 0, 0, F, "undef_f");
        cyc(32'hFC000000, 0, 0, e(1,0,1,0,0,0,0,0,0,0,0,0,0,0), "undef_d");

        // sw stalled in MEM, then reset abandons it.
        cyc(32'hAD080004, 0, 0, F, "swr_f");
        cyc(32'hAD080004, 0, 0, D, "swr_d");
        cyc(32'hAD080004, 0, 0, e(2,0,0,0,0,0,0,0,0,1,1,0,0,0), "swr_e");
        cyc(32'hAD080004, 0, 0, e(3,0,0,0,0,0,0,0,0,1,1,0,1,0), "swr_m0");
        cyc(32'hAD080004, 0, 0, e(3,0,0,0,0,0,0,0,0,1,1,0,1,0), "swr_m1");
        cyc(32'hAD080004, 0, 1, e(3,0,0,0,0,0,0,0,0,1,1,0,0,0), "swr_rst");
        cyc(32'h00000000, 0, 0, F, "post_f");
        cyc(32'h00000000, 0, 0, e(1,0,1,0,0,0,0,0,0,0,0,0,0,0), "post_d");
        cyc(32'h00000000, 0, 0, F, "post_f2");

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
